// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write arbiter.
package fifo_arb_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  localparam int DW_DEF = 4;
  localparam int DEPTH_DEF = 8;
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  localparam int OCC_W = occ_w(DEPTH_DEF);
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  // Scan from the farthest offset down so the nearest one wins.
  always_comb begin
    onehot = '0;
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        onehot = N'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter: round-robin burst arbiter for a FIFO write port with credit tracking.
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*DW-1:0]           req_data,
  output logic [NREQ-1:0]              req_ready,
  output logic [NREQ-1:0]              grant,
  output logic                         fifo_wr_en,
  output logic [DW-1:0]                fifo_wr_data,
  input  logic                         fifo_rd_en,
  input  logic                         fifo_empty,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         busy
);
  localparam int OW = occ_w(DEPTH);
  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state, state_n;
  logic [NREQ-1:0] grant_n, pick_oh;
  logic [PW-1:0] owner, owner_n, rr_ptr, rr_ptr_n, pick_idx;
  logic [BW-1:0] beat_cnt, beat_cnt_n;
  logic [OW-1:0] occ_n;
  logic [DW-1:0] owner_data;
  logic hs, rd, room;
  rr_pick #(.N(NREQ)) u_pick (
    .req(req_valid),
    .ptr(rr_ptr),
    .onehot(pick_oh),
    .idx(pick_idx)
  );
  // Credits are taken at accept time, so the write latency cannot overrun the FIFO.
  assign room = occupancy < OW'(DEPTH);
  assign req_ready = (state == BURST && room) ? grant : '0;
  assign hs = |(req_valid & req_ready);
  assign rd = fifo_rd_en & ~fifo_empty;
  assign owner_data = req_data[owner*DW +: DW];
  assign busy = state == BURST;
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    rr_ptr_n = rr_ptr;
    beat_cnt_n = beat_cnt;
    occ_n = (hs && !rd) ? occupancy + 1'b1 : (!hs && rd) ? occupancy - 1'b1 : occupancy;
    if (state == IDLE) begin
      if (|req_valid) begin
        state_n = BURST;
        grant_n = pick_oh;
        owner_n = pick_idx;
        beat_cnt_n = '0;
      end
    end else if (!req_valid[owner] || (hs && beat_cnt == BW'(MAX_BURST - 1))) begin
      state_n = IDLE;
      grant_n = '0;
      rr_ptr_n = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;
    end else if (hs) begin
      beat_cnt_n = beat_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      owner <= '0;
      rr_ptr <= '0;
      beat_cnt <= '0;
      occupancy <= '0;
      fifo_wr_en <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      owner <= owner_n;
      rr_ptr <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
      occupancy <= occ_n;
      fifo_wr_en <= hs;
      if (hs) fifo_wr_data <= owner_data;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter: random stimulus against a behavioural arbiter model with a write-data scoreboard.
module tb_fifo_write_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 4;
  localparam int DEPTH = 8;
  localparam int MAX_BURST = 4;
  localparam int OW = $clog2(DEPTH + 1);
  logic clk = 1'b0;
  logic rst;
  logic [NREQ-1:0] req_valid, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic fifo_wr_en, fifo_rd_en, fifo_empty, busy;
  logic [DW-1:0] fifo_wr_data;
  logic [OW-1:0] occupancy;
  int checks = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];
  bit m_busy, m_wr;
  int m_owner, m_beats, m_ptr, m_occ, fcnt;
  logic [DW-1:0] m_wdata;
  int p_mask[6] = '{1, 15, 15, 15, 2, 0};
  int p_vpct[6] = '{100, 100, 70, 50, 100, 0};
  int p_rpct[6] = '{0, 100, 30, 60, 10, 100};
  int p_rst[6]  = '{0, 0, 0, 3, 0, 0};
  int p_len[6]  = '{24, 60, 400, 400, 100, 24};
  always #5 clk = ~clk;
  fifo_write_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ready(req_ready),
    .grant(grant),
    .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data),
    .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty),
    .occupancy(occupancy),
    .busy(busy)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // Each beat the FIFO write port delivers must be the oldest accepted beat.
  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_write", 1, 0);
      else chk("wr_data", fifo_wr_data, exp_q.pop_front());
    end
  end
  task automatic check_outputs();
    logic [NREQ-1:0] g, r;
    g = m_busy ? NREQ'(1) << m_owner : '0;
    r = (m_busy && m_occ < DEPTH) ? g : '0;
    chk("grant", grant, g);
    chk("req_ready", req_ready, r);
    chk("busy", busy, m_busy);
    chk("occupancy", occupancy, m_occ);
    chk("fifo_wr_en", fifo_wr_en, m_wr);
    chk("fifo_wr_data", fifo_wr_data, m_wdata);
  endtask
  // Advance the reference model across the coming clock edge.
  task automatic step();
    bit hs, rd;
    int w;
    rd = fifo_rd_en && !fifo_empty;
    hs = m_busy && m_occ < DEPTH && req_valid[m_owner];
    if (rst) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_occ = 0; m_wr = 0; m_wdata = '0; fcnt = 0;
      return;
    end
    fcnt += int'(m_wr) - int'(rd);
    m_wr = hs;
    if (hs) begin
      m_wdata = req_data[m_owner*DW +: DW];
      exp_q.push_back(m_wdata);
    end
    m_occ += int'(hs) - int'(rd);
    if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        w = (m_ptr + k) % NREQ;
        if (!m_busy && req_valid[w]) begin
          m_busy = 1;
          m_owner = w;
          m_beats = 0;
        end
      end
    end else begin
      if (hs) m_beats++;
      if (!req_valid[m_owner] || m_beats == MAX_BURST) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % NREQ;
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    fifo_rd_en = 1'b0;
    fifo_empty = 1'b1;
    step();
    for (int p = 0; p < 6; p++) begin
      for (int c = 0; c < p_len[p]; c++) begin
        @(negedge clk);
        check_outputs();
        rst = $urandom_range(99) < p_rst[p];
        for (int i = 0; i < NREQ; i++)
          req_valid[i] = p_mask[p][i] && ($urandom_range(99) < p_vpct[p]);
        req_data = NREQ*DW'($urandom);
        fifo_rd_en = $urandom_range(99) < p_rpct[p];
        fifo_empty = fcnt == 0;
        step();
      end
    end
    @(negedge clk);
    check_outputs();
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
